// File: rtl/ehl_apb_burst_master.sv
// ehl_apb_burst_master
//   APB master that turns burst commands into a sequence of single-word APB
//   transfers at word-incrementing addresses (wrapping modulo 2^AWIDTH).
//   Write bursts pull one beat per transfer from the write-data stream; read
//   bursts push one beat per transfer onto the read-data stream. A one-cycle
//   done pulse with the OR of all pslverr responses closes every burst.
//
// Ports
//   pclk, presetn              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        burst command handshake
//   cmd_write, cmd_addr,       direction, start byte address (bits [1:0]
//   cmd_len                      ignored), beats minus one
//   wd_valid/wd_ready, wd_data write-data stream (one beat per APB write)
//   rd_valid/rd_ready, rd_data read-data stream, rd_err = pslverr of the beat
//     rd_err
//   done, done_err             end-of-burst pulse and accumulated error
//   paddr, pwrite, psel,       APB master request signals
//     penable, pwdata
//   pready, pslverr, prdata    APB slave response signals
//
// Every output is a flop or a decode of the one-hot state flops, so there is
// no combinational path from any input to any output.

module ehl_apb_burst_master #(
    parameter int AWIDTH      = 10,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   pclk,
    input  logic                   presetn,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AWIDTH-1:0]      cmd_addr,
    input  logic [BURST_WIDTH-1:0] cmd_len,

    input  logic                   wd_valid,
    output logic                   wd_ready,
    input  logic [31:0]            wd_data,

    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_data,
    output logic                   rd_err,

    output logic                   done,
    output logic                   done_err,

    output logic [31:0]            paddr,
    output logic                   pwrite,
    output logic                   psel,
    output logic                   penable,
    output logic [31:0]            pwdata,
    input  logic                   pready,
    input  logic                   pslverr,
    input  logic [31:0]            prdata
);

    // One-hot state encoding; bit positions double as decode indices.
    localparam int B_IDLE   = 0;
    localparam int B_FETCH  = 1;
    localparam int B_SETUP  = 2;
    localparam int B_ACCESS = 3;
    localparam int B_RESP   = 4;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_FETCH  = 5'b00010;
    localparam logic [4:0] S_SETUP  = 5'b00100;
    localparam logic [4:0] S_ACCESS = 5'b01000;
    localparam logic [4:0] S_RESP   = 5'b10000;

    logic [4:0]             state_q,    state_d;
    logic [AWIDTH-1:0]      addr_q,     addr_d;
    logic [BURST_WIDTH-1:0] cnt_q,      cnt_d;
    logic                   write_q,    write_d;
    logic                   err_q,      err_d;
    logic [31:0]            pwdata_q,   pwdata_d;
    logic [31:0]            rd_data_q,  rd_data_d;
    logic                   rd_err_q,   rd_err_d;
    logic                   done_q,     done_d;
    logic                   done_err_q, done_err_d;

    logic last_beat;

    assign last_beat = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        err_d      = err_q;
        pwdata_d   = pwdata_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Word-align by masking so every address bit is consumed.
                    addr_d  = cmd_addr & ~AWIDTH'(3);
                    cnt_d   = cmd_len;
                    write_d = cmd_write;
                    err_d   = 1'b0;
                    state_d = cmd_write ? S_FETCH : S_SETUP;
                end
            end

            S_FETCH: begin
                if (wd_valid) begin
                    pwdata_d = wd_data;
                    state_d  = S_SETUP;
                end
            end

            S_SETUP: begin
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready) begin
                    err_d = err_q | pslverr;
                    if (!write_q) begin
                        rd_data_d = prdata;
                        rd_err_d  = pslverr;
                        state_d   = S_RESP;
                    end else if (last_beat) begin
                        done_d     = 1'b1;
                        done_err_d = err_q | pslverr;
                        state_d    = S_IDLE;
                    end else begin
                        addr_d  = addr_q + AWIDTH'(4);
                        cnt_d   = cnt_q - BURST_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end

            S_RESP: begin
                if (rd_ready) begin
                    if (last_beat) begin
                        done_d     = 1'b1;
                        done_err_d = err_q;
                        state_d    = S_IDLE;
                    end else begin
                        addr_d  = addr_q + AWIDTH'(4);
                        cnt_d   = cnt_q - BURST_WIDTH'(1);
                        state_d = S_SETUP;
                    end
                end
            end

            default: begin
                // Any non-one-hot value recovers to IDLE.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            pwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            err_q      <= err_d;
            pwdata_q   <= pwdata_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    assign cmd_ready = state_q[B_IDLE];
    assign wd_ready  = state_q[B_FETCH];
    assign psel      = state_q[B_SETUP] | state_q[B_ACCESS];
    assign penable   = state_q[B_ACCESS];
    assign rd_valid  = state_q[B_RESP];

    assign paddr     = {{(32-AWIDTH){1'b0}}, addr_q};
    assign pwrite    = write_q;
    assign pwdata    = pwdata_q;
    assign rd_data   = rd_data_q;
    assign rd_err    = rd_err_q;
    assign done      = done_q;
    assign done_err  = done_err_q;

endmodule

// File: tb/tb_ehl_apb_burst_master.sv
// Self-checking bench for ehl_apb_burst_master. A burst-level reference model
// (expected address list, data FIFOs, word memory) is compared with the APB
// and stream activity observed once per cycle on the falling clock edge.

module tb_ehl_apb_burst_master;

    localparam int AW = 10;
    localparam int BW = 8;
    localparam int MW = 1 << (AW - 2);

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_len = '0;
    logic          wd_valid = 1'b0, wd_ready;
    logic [31:0]   wd_data = '0;
    logic          rd_valid, rd_ready = 1'b0, rd_err;
    logic [31:0]   rd_data;
    logic          done, done_err;
    logic [31:0]   paddr, pwdata, prdata = '0;
    logic          pwrite, psel, penable, pready = 1'b0, pslverr = 1'b0;

    ehl_apb_burst_master #(.AWIDTH(AW), .BURST_WIDTH(BW)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err),
        .done(done), .done_err(done_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [BW-1:0] len;
    } cmd_t;

    cmd_t        cq[$];
    logic [31:0] wd_src[$];
    logic [31:0] wexp[$];
    logic [31:0] rexp[$];
    logic        rerr[$];
    logic [31:0] ref_mem[MW];
    logic [31:0] slv_mem[MW];

    logic busy = 1'b0;
    cmd_t cur;
    int   apb_i, rd_i, nbeats;
    logic err_acc;
    logic done_due = 1'b0, done_due_err = 1'b0;

    // stimulus knobs
    int pr_pct = 100, wd_pct = 100, rr_pct = 100, err_pct = 0;
    int err_beat = -1;
    int p_stall_beat = -1, p_stall_cyc = 0;
    int rd_stall_beat = -1, rd_stall_cyc = 0;
    int wd_delay = 0;
    bit check_rate = 1'b0;

    int p_stall = 0, rd_stall = 0, wd_wait = 0;
    int cyc = 0, last_hs = 0;

    logic        pv_psel = 0, pv_pen = 0, pv_prdy = 0, pv_pwrite = 0;
    logic        pv_rdv = 0, pv_rdr = 0, pv_rerr = 0;
    logic [31:0] pv_paddr = '0, pv_pwdata = '0, pv_rdata = '0;

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic init_mems();
        for (int i = 0; i < MW; i++) begin
            logic [31:0] v;
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
    endtask

    // A burst touches words base, base+4, ... modulo 2^AW.
    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input int len, input logic [31:0] dbase);
        cmd_t c;
        logic [AW-1:0] base, ad;
        logic [31:0] d;
        c.w = w; c.a = a; c.len = BW'(len);
        base = a & ~AW'(3);
        for (int i = 0; i <= len; i++) begin
            ad = base + AW'(4 * i);
            if (w) begin
                d = (dbase != 0) ? dbase + 32'(i) : $urandom;
                wd_src.push_back(d);
                wexp.push_back(d);
                ref_mem[ad[AW-1:2]] = d;
            end else begin
                rexp.push_back(ref_mem[ad[AW-1:2]]);
            end
        end
        cq.push_back(c);
    endtask

    task automatic finish_burst();
        done_due     = 1'b1;
        done_due_err = err_acc;
        busy         = 1'b0;
    endtask

    // One cycle of checking, input driving and handshake bookkeeping.
    // Runs on the falling edge; handshakes recorded here complete at the
    // following rising edge.
    task automatic step();
        logic [AW-1:0] ea;
        cyc++;

        check_eq("done", done, done_due);
        if (done_due) check_eq("done_err", done_err, done_due_err);
        done_due = 1'b0;
        check_eq("cmd_ready", cmd_ready, !busy);
        if (psel) begin
            check_eq("psel_busy", busy, 1);
            check_eq("paddr_hi", paddr[31:AW], 0);
        end
        if (rd_valid) check_eq("psel_in_resp", psel, 0);
        if (wd_ready) check_eq("psel_in_fetch", psel, 0);
        if (penable) check_eq("setup_before_access", pv_psel, 1);
        if (pv_psel && pv_pen && !pv_prdy) begin
            check_eq("access_hold", {psel, penable}, 2'b11);
            check_eq("paddr_stable", paddr, pv_paddr);
            check_eq("pwrite_stable", pwrite, pv_pwrite);
            if (pv_pwrite) check_eq("pwdata_stable", pwdata, pv_pwdata);
        end
        if (pv_rdv && !pv_rdr) begin
            check_eq("rd_valid_hold", rd_valid, 1);
            check_eq("rd_data_stable", rd_data, pv_rdata);
            check_eq("rd_err_stable", rd_err, pv_rerr);
        end

        // command stream
        cmd_valid = !busy && (cq.size() > 0);
        if (cmd_valid) begin
            cmd_write = cq[0].w;
            cmd_addr  = cq[0].a;
            cmd_len   = cq[0].len;
        end else begin
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_len   = BW'($urandom);
        end

        // write-data stream
        if (wd_wait > 0) wd_wait--;
        wd_valid = busy && cur.w && (wd_src.size() > 0) && (wd_wait == 0) && rnd(wd_pct);
        wd_data  = wd_valid ? wd_src[0] : $urandom;

        // APB slave
        if (psel && !penable && apb_i == p_stall_beat) p_stall = p_stall_cyc;
        if (psel && penable && p_stall > 0) begin
            pready = 1'b0;
            p_stall--;
        end else begin
            pready = rnd(pr_pct);
        end
        pslverr = (err_beat >= 0) ? (apb_i == err_beat) : rnd(err_pct);
        prdata  = (psel && !pwrite && pready) ? slv_mem[paddr[AW-1:2]] : $urandom;

        // read-data consumer
        if (rd_valid && !pv_rdv && rd_i == rd_stall_beat) rd_stall = rd_stall_cyc;
        if (rd_valid && rd_stall > 0) begin
            rd_ready = 1'b0;
            rd_stall--;
        end else begin
            rd_ready = rnd(rr_pct);
        end

        // handshakes completing at the next rising edge
        if (cmd_valid && cmd_ready) begin
            cur     = cq.pop_front();
            busy    = 1'b1;
            apb_i   = 0;
            rd_i    = 0;
            nbeats  = int'(cur.len) + 1;
            err_acc = 1'b0;
            wd_wait = wd_delay;
        end
        if (wd_valid && wd_ready) void'(wd_src.pop_front());
        if (psel && penable && pready) begin
            check_eq("extra_beat", apb_i < nbeats, 1);
            ea = (cur.a & ~AW'(3)) + AW'(4 * apb_i);
            check_eq("paddr", paddr, {{(32-AW){1'b0}}, ea});
            check_eq("pwrite", pwrite, cur.w);
            if (cur.w) begin
                check_eq("wexp_avail", wexp.size() > 0, 1);
                if (wexp.size() > 0) check_eq("pwdata", pwdata, wexp.pop_front());
                slv_mem[paddr[AW-1:2]] = pwdata;
            end else begin
                rerr.push_back(pslverr);
            end
            if (check_rate && apb_i > 0) check_eq("beat_cycles", cyc - last_hs, 3);
            last_hs = cyc;
            err_acc = err_acc | pslverr;
            apb_i++;
            if (cur.w && apb_i == nbeats) finish_burst();
        end
        if (rd_valid && rd_ready) begin
            check_eq("rd_expected", (rexp.size() > 0) && (rerr.size() > 0), 1);
            if (rexp.size() > 0) check_eq("rd_data", rd_data, rexp.pop_front());
            if (rerr.size() > 0) check_eq("rd_err", rd_err, rerr.pop_front());
            rd_i++;
            if (rd_i == nbeats) finish_burst();
        end

        pv_psel = psel;  pv_pen = penable; pv_prdy = pready; pv_pwrite = pwrite;
        pv_paddr = paddr; pv_pwdata = pwdata;
        pv_rdv = rd_valid; pv_rdr = rd_ready; pv_rdata = rd_data; pv_rerr = rd_err;
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            if (presetn) step();
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || cq.size() > 0) && n < budget) begin
            @(posedge pclk);
            n++;
        end
        check_eq("timeout", n >= budget, 0);
        repeat (2) @(posedge pclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_psel"},     psel, 0);
        check_eq({tag, "_penable"},  penable, 0);
        check_eq({tag, "_done"},     done, 0);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_rd_valid"}, rd_valid, 0);
        check_eq({tag, "_wd_ready"}, wd_ready, 0);
        check_eq({tag, "_paddr"},    paddr, 0);
        check_eq({tag, "_pwdata"},   pwdata, 0);
        check_eq({tag, "_rd_data"},  rd_data, 0);
    endtask

    task automatic clear_model();
        cq.delete(); wd_src.delete(); wexp.delete(); rexp.delete(); rerr.delete();
        busy = 1'b0; done_due = 1'b0; p_stall = 0; rd_stall = 0; wd_wait = 0;
        cmd_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        pv_psel = 0; pv_pen = 0; pv_prdy = 0; pv_rdv = 0; pv_rdr = 0;
    endtask

    task automatic set_fast();
        pr_pct = 100; wd_pct = 100; rr_pct = 100; err_pct = 0; err_beat = -1;
        p_stall_beat = -1; rd_stall_beat = -1; wd_delay = 0;
    endtask

    initial begin
        init_mems();
        repeat (3) @(posedge pclk);
        #1 check_reset_outputs("por");
        check_eq("por_pwrite", pwrite, 0);
        check_eq("por_rd_err", rd_err, 0);
        check_eq("por_done_err", done_err, 0);
        @(negedge pclk); #2 presetn = 1'b1;

        // reset in the middle of a write burst
        pr_pct = 70; wd_pct = 70; rr_pct = 70;
        push_cmd(1'b1, AW'($urandom), 15, 0);
        repeat (20) @(posedge pclk);
        @(negedge pclk); #2 presetn = 1'b0;
        clear_model();
        #1 check_reset_outputs("midrst");
        init_mems();
        repeat (3) @(posedge pclk);
        @(negedge pclk); #2 presetn = 1'b1;
        repeat (3) @(posedge pclk);

        // 4-beat write at 0x012 with data A0..A3, full-rate slave and streams
        set_fast();
        check_rate = 1'b1;
        push_cmd(1'b1, 10'h012, 3, 32'hA0);
        wait_idle(200);
        check_rate = 1'b0;

        // read back with the consumer stalling 5 cycles on the second beat
        rd_stall_beat = 1; rd_stall_cyc = 5;
        push_cmd(1'b0, 10'h012, 3, 0);
        wait_idle(200);
        rd_stall_beat = -1;

        // address wrap at the top of the space, write then read
        check_rate = 1'b1;
        push_cmd(1'b1, 10'h3F8, 3, 0);
        push_cmd(1'b0, 10'h3F8, 3, 0);
        wait_idle(200);
        check_rate = 1'b0;

        // wait states and an error on the first beat of a 2-beat read
        err_beat = 0; p_stall_beat = 0; p_stall_cyc = 3;
        push_cmd(1'b0, 10'h100, 1, 0);
        wait_idle(200);
        set_fast();

        // single-beat write with late write data
        wd_delay = 4;
        push_cmd(1'b1, AW'($urandom), 0, 0);
        wait_idle(200);
        set_fast();

        // randomized back-to-back traffic
        pr_pct = 60; wd_pct = 60; rr_pct = 60; err_pct = 20;
        for (int i = 0; i < 40; i++)
            push_cmd(1'($urandom), AW'($urandom), $urandom_range(15), 0);
        push_cmd(1'b1, AW'($urandom), 255, 0);
        push_cmd(1'b0, AW'($urandom), 255, 0);
        wait_idle(30000);

        check_eq("wd_left", wd_src.size(), 0);
        check_eq("wexp_left", wexp.size(), 0);
        check_eq("rexp_left", rexp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
